// File: rtl/wfm_capture_seq_if.sv
// wfm_capture_seq_if: local register bus between the CPU bridge and the capture sequencer.
//   lb_addr   register word index (bridge -> sequencer)
//   lb_wdata  write data (bridge -> sequencer)
//   lb_we     one-cycle write strobe (bridge -> sequencer)
//   lb_re     one-cycle read strobe (bridge -> sequencer)
//   lb_rdata  read data, valid with lb_rvalid, else 0 (sequencer -> bridge)
//   lb_rvalid read data valid, one cycle after lb_re (sequencer -> bridge)
interface wfm_capture_seq_if;
    logic [1:0]  lb_addr;
    logic [31:0] lb_wdata;
    logic        lb_we;
    logic        lb_re;
    logic [31:0] lb_rdata;
    logic        lb_rvalid;
    modport master (output lb_addr, lb_wdata, lb_we, lb_re, input lb_rdata, lb_rvalid);
    modport slave  (input lb_addr, lb_wdata, lb_we, lb_re, output lb_rdata, lb_rvalid);
endinterface

// File: rtl/wfm_capture_seq.sv
// wfm_capture_seq: arms a waveform capture, fills pre-trigger samples, waits for a
// trigger, records post-trigger samples into a circular buffer, then flags done/irq.
//   mem_clk       system clock
//   reset         synchronous, active-low reset
//   lb            local register bus (slave side)
//   sample_stb_i  one-cycle pulse per new sample
//   trig_in_i     asynchronous trigger level
//   buf_we_o      buffer write enable
//   buf_waddr_o   buffer write address
//   trig_addr_o   address of the first post-trigger sample
//   done_o        capture complete (level)
//   irq_o         one-cycle pulse on entry to DONE
// Build option: define WFM_SEQ_TIMEOUT_EN to auto-trigger after TIMEOUT_SAMPLES armed samples.
module wfm_capture_seq #(
    parameter int AW              = 10,
    parameter int POST_DEFAULT    = 512,
    parameter int TIMEOUT_SAMPLES = 4096
) (
    input  logic             mem_clk,
    input  logic             reset,
    wfm_capture_seq_if.slave lb,
    input  logic             sample_stb_i,
    input  logic             trig_in_i,
    output logic             buf_we_o,
    output logic [AW-1:0]    buf_waddr_o,
    output logic [AW-1:0]    trig_addr_o,
    output logic             done_o,
    output logic             irq_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
    state_t        state_q;
    logic [AW-1:0] waddr_q, pre_len_q, pre_cnt_q, trig_addr_q, buf_waddr_q;
    logic [AW:0]   post_len_q, post_eff_q, post_cnt_q;
    logic          sync1_q, sync2_q, sync3_q, buf_we_q, done_q, irq_q, timeout_q, rvalid_q;
    logic [31:0]   rdata_q;
    logic          ctrl_we, arm, force_trig, abort, trig_edge, trig, auto_trig, wr;
    logic [AW:0]   pre_cnt_d, post_cnt_d, room, post_eff_d;
    logic [31:0]   status, rdata_d;
    logic          unused;

    assign unused = ^lb.lb_wdata[31:AW+1];

`ifdef WFM_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TW-1:0] to_cnt_q;
    // Counts samples seen while ARMED; cleared whenever the sequencer is elsewhere.
    always_ff @(posedge mem_clk) begin
        if (!reset || state_q != ARMED) to_cnt_q <= '0;
        else if (sample_stb_i) to_cnt_q <= to_cnt_q + TW'(1);
    end
    assign auto_trig = state_q == ARMED && to_cnt_q == TW'(TIMEOUT_SAMPLES);
`else
    localparam int unused_timeout = TIMEOUT_SAMPLES;
    assign auto_trig = 1'b0;
`endif

    always_comb begin
        ctrl_we    = lb.lb_we && lb.lb_addr == 2'd0;
        abort      = ctrl_we && lb.lb_wdata[2];
        arm        = ctrl_we && lb.lb_wdata[0] && !abort && (state_q == IDLE || state_q == DONE);
        force_trig = ctrl_we && lb.lb_wdata[1];
        trig_edge  = sync2_q && !sync3_q;
        trig       = trig_edge || force_trig || auto_trig;
        pre_cnt_d  = {1'b0, pre_cnt_q} + (AW+1)'(1);
        post_cnt_d = post_cnt_q + (AW+1)'(1);
        // Post length is clipped so pre + post never exceed the buffer depth.
        room       = {1'b1, {AW{1'b0}}} - {1'b0, pre_len_q};
        post_eff_d = post_len_q < room ? post_len_q : room;
        // A sample arriving with the trigger is the first post sample, unless no post samples are wanted.
        wr = sample_stb_i && !abort &&
             (state_q == PRE ||
              (state_q == ARMED && !(trig && post_eff_q == '0)) ||
              (state_q == POST && post_cnt_q != post_eff_q));
        status        = '0;
        status[2:0]   = state_q;
        status[3]     = done_q;
        status[4]     = timeout_q;
        status[AW+15:16] = trig_addr_q;
        rdata_d = !lb.lb_re           ? 32'd0 :
                  lb.lb_addr == 2'd1  ? status :
                  lb.lb_addr == 2'd2  ? 32'(pre_len_q) :
                  lb.lb_addr == 2'd3  ? 32'(post_len_q) : 32'd0;
    end

    always_ff @(posedge mem_clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            pre_len_q   <= '0;
            pre_cnt_q   <= '0;
            trig_addr_q <= '0;
            buf_waddr_q <= '0;
            post_len_q  <= (AW+1)'(POST_DEFAULT);
            post_eff_q  <= '0;
            post_cnt_q  <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            buf_we_q    <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            timeout_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            sync1_q  <= trig_in_i;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            rvalid_q <= lb.lb_re;
            rdata_q  <= rdata_d;
            buf_we_q <= wr;
            irq_q    <= 1'b0;
            if (wr) begin
                buf_waddr_q <= waddr_q;
                waddr_q     <= waddr_q + AW'(1);
            end
            if (lb.lb_we && lb.lb_addr == 2'd2) pre_len_q <= lb.lb_wdata[AW-1:0];
            if (lb.lb_we && lb.lb_addr == 2'd3) post_len_q <= lb.lb_wdata[AW:0];
            if (abort) begin
                state_q <= IDLE;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: if (arm) begin
                        state_q    <= pre_len_q == '0 ? ARMED : PRE;
                        done_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                        pre_cnt_q  <= '0;
                        post_cnt_q <= '0;
                        post_eff_q <= post_eff_d;
                    end
                    PRE: if (sample_stb_i) begin
                        pre_cnt_q <= pre_cnt_d[AW-1:0];
                        if (pre_cnt_d >= {1'b0, pre_len_q}) state_q <= ARMED;
                    end
                    ARMED: if (trig) begin
                        state_q     <= POST;
                        trig_addr_q <= waddr_q;
                        post_cnt_q  <= {{AW{1'b0}}, wr};
                        timeout_q   <= auto_trig && !trig_edge && !force_trig;
                    end
                    POST: begin
                        if (post_cnt_q == post_eff_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            irq_q   <= 1'b1;
                        end else if (sample_stb_i) begin
                            post_cnt_q <= post_cnt_d;
                            if (post_cnt_d == post_eff_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                irq_q   <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign buf_we_o     = buf_we_q;
    assign buf_waddr_o  = buf_waddr_q;
    assign trig_addr_o  = trig_addr_q;
    assign done_o       = done_q;
    assign irq_o        = irq_q;
    assign lb.lb_rdata  = rdata_q;
    assign lb.lb_rvalid = rvalid_q;
endmodule
